// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: default timer durations and the light-phase encoding.
package traffic_pkg;

  localparam int unsigned TP_SHORT_TICKS = 5;
  localparam int unsigned TP_LONG_TICKS  = 12;
  localparam int unsigned TP_PRESCALE    = 4;
  localparam int unsigned TP_CW          = 4;

  typedef enum logic [1:0] {
    PH_HWY_GREEN   = 2'd0,
    PH_HWY_YELLOW  = 2'd1,
    PH_FARM_GREEN  = 2'd2,
    PH_FARM_YELLOW = 2'd3
  } light_phase_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler for traffic_timer: one-cycle registered tick every PRESCALE clks, phase-aligned to the last clear.
module tick_gen
  import traffic_pkg::*;
#(
  parameter int unsigned PRESCALE = TP_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  // The clear cycle itself counts as elapsed cycle 0, so the cycle after holds phase 1.
  localparam logic [PW-1:0] LOAD = PW'(1 % PRESCALE);

  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_next;

  // Next prescaler phase: reload on clear/reset, wrap after the last phase.
  always_comb begin
    pcnt_next = pcnt + PW'(1);
    if (rst || clr) begin
      pcnt_next = LOAD;
    end else if (pcnt == LAST) begin
      pcnt_next = '0;
    end
  end

  // Phase register and registered tick (high while the phase sits on the last slot).
  always_ff @(posedge clk) begin
    pcnt <= pcnt_next;
    tick <= (pcnt_next == LAST);
  end

endmodule

// File: rtl/traffic_timer.sv
// Combined short/long interval timer for the traffic-light controller.
// Build option: define TRAFFIC_TIMER_PRESCALE_EN to insert the tick_gen prescaler;
// without it every clk is a tick and PRESCALE is ignored.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int unsigned PRESCALE    = TP_PRESCALE,
  parameter int unsigned SHORT_TICKS = TP_SHORT_TICKS,
  parameter int unsigned LONG_TICKS  = TP_LONG_TICKS,
  parameter int unsigned CW          = TP_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st,
  output logic          ts,
  output logic          tl,
  output logic [CW-1:0] lcnt
);

`ifdef TRAFFIC_TIMER_PRESCALE_EN
  localparam int unsigned EFF_P = PRESCALE;
`else
  // PRESCALE has no effect without the prescaler.
  localparam int unsigned EFF_P = (PRESCALE == 0) ? 1 : 1;
`endif

  localparam logic [CW-1:0] S_LAST = CW'(SHORT_TICKS - 1);
  localparam logic [CW-1:0] L_MAX  = CW'(LONG_TICKS);
  // With one tick per clk the clear cycle is already the first tick; its expiry is
  // suppressed, but the internal counters start one tick ahead so cycle n sees n ticks.
  localparam logic [CW-1:0] S_LOAD = (EFF_P == 1 && SHORT_TICKS > 1) ? CW'(1) : CW'(0);
  localparam logic [CW-1:0] L_LOAD = (EFF_P == 1) ? CW'(1) : CW'(0);

  logic          clr;
  logic          tick;
  logic [CW-1:0] scnt;
  logic [CW-1:0] scnt_next;
  logic [CW-1:0] lcount;
  logic [CW-1:0] lcount_next;
  logic [CW-1:0] lcnt_next;
  logic          ts_next;
  logic          tl_next;

  assign clr = rst | st;

`ifdef TRAFFIC_TIMER_PRESCALE_EN
  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (st),
    .tick(tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Counter advance and expiry decode; a clear (st or rst) overrides any coincident expiry.
  always_comb begin
    scnt_next   = scnt;
    lcount_next = lcount;
    lcnt_next   = '0;
    ts_next     = 1'b0;
    tl_next     = 1'b0;
    if (clr) begin
      scnt_next   = S_LOAD;
      lcount_next = L_LOAD;
    end else begin
      if (tick) begin
        if (scnt == S_LAST) begin
          scnt_next = '0;
          ts_next   = 1'b1;
        end else begin
          scnt_next = scnt + CW'(1);
        end
        if (lcount != L_MAX) begin
          lcount_next = lcount + CW'(1);
        end
      end
      tl_next   = (lcount_next == L_MAX);
      lcnt_next = lcount_next;
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk) begin
    scnt   <= scnt_next;
    lcount <= lcount_next;
    ts     <= ts_next;
    tl     <= tl_next;
    lcnt   <= lcnt_next;
  end

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench for traffic_timer; follows TRAFFIC_TIMER_PRESCALE_EN for the tick period.
module tb_traffic_timer;

  localparam int S  = 5;
  localparam int L  = 12;
  localparam int CW = 4;
`ifdef TRAFFIC_TIMER_PRESCALE_EN
  localparam int EP = 4;
`else
  localparam int EP = 1;
`endif

  typedef struct packed {
    logic          ts;
    logic          tl;
    logic [CW-1:0] lcnt;
  } out_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st  = 1'b0;
  logic          ts;
  logic          tl;
  logic [CW-1:0] lcnt;

  out_t sb[$];
  int   n        = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  traffic_timer #(
    .PRESCALE   (4),
    .SHORT_TICKS(S),
    .LONG_TICKS (L),
    .CW         (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .st  (st),
    .ts  (ts),
    .tl  (tl),
    .lcnt(lcnt)
  );

  // Expected outputs k cycles after the last clear cycle (k=1 is the cleared cycle).
  function automatic out_t model(input int k);
    out_t e;
    int   q;
    e = '0;
    if (k >= 2) begin
      q = k / EP;
      if (q > L) q = L;
      e.ts   = ((k % (S * EP)) == 0);
      e.tl   = (k >= L * EP);
      e.lcnt = CW'(q);
    end
    return e;
  endfunction

  // Drive one cycle of inputs, push the expected result, sample #1 after the edge.
  task automatic drive(input logic s, input logic r);
    @(negedge clk);
    st  = s;
    rst = r;
    n   = (s || r) ? 1 : n + 1;
    sb.push_back(model(n));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t got, exp;
    int first_ts = -1;
    int first_tl = -1;
    int pulses   = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1);
      got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_hold i=%0d: got ts=%b tl=%b lcnt=%0d, want ts=%b tl=%b lcnt=%0d",
                 i, got.ts, got.tl, got.lcnt, exp.ts, exp.tl, exp.lcnt);
      end
    end
    for (int k = 2; k <= 4 * S * EP - 1; k++) begin
      drive(1'b0, 1'b0);
      got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_run cycle=%0d: got ts=%b tl=%b lcnt=%0d, want ts=%b tl=%b lcnt=%0d",
                 k, got.ts, got.tl, got.lcnt, exp.ts, exp.tl, exp.lcnt);
      end
      if (ts === 1'b1) begin
        pulses++;
        if (first_ts < 0) first_ts = k;
      end
      if (tl === 1'b1 && first_tl < 0) first_tl = k;
    end
    n_checks++;
    if (first_ts != S * EP) begin
      n_fail++; $display("FAIL reset_first_ts: got %0d want %0d", first_ts, S * EP);
    end
    n_checks++;
    if (first_tl != L * EP) begin
      n_fail++; $display("FAIL reset_first_tl: got %0d want %0d", first_tl, L * EP);
    end
    n_checks++;
    if (pulses != 3) begin
      n_fail++; $display("FAIL reset_pulse_count: got %0d want 3", pulses);
    end
    n_checks++;
    if (lcnt !== CW'(L)) begin
      n_fail++; $display("FAIL reset_lcnt_sat: got %0d want %0d", lcnt, L);
    end
  endtask

  task automatic test_st_restart();
    out_t got, exp;
    int st_c     = S * EP + 2 * EP + 2;
    int first_ts = -1;
    int first_tl = -1;
    drive(1'b0, 1'b1);
    void'(sb.pop_front());
    for (int k = 2; k <= st_c; k++) begin
      drive(1'b0, 1'b0);
      got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL restart_pre cycle=%0d: got ts=%b tl=%b lcnt=%0d, want ts=%b tl=%b lcnt=%0d",
                 k, got.ts, got.tl, got.lcnt, exp.ts, exp.tl, exp.lcnt);
      end
    end
    drive(1'b1, 1'b0);
    got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
    if (got !== exp || got !== out_t'(0)) begin
      n_fail++;
      $display("FAIL restart_clear: got ts=%b tl=%b lcnt=%0d, want all 0", got.ts, got.tl, got.lcnt);
    end
    for (int j = 2; j <= L * EP + 2; j++) begin
      drive(1'b0, 1'b0);
      got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL restart_post cycle=%0d: got ts=%b tl=%b lcnt=%0d, want ts=%b tl=%b lcnt=%0d",
                 j, got.ts, got.tl, got.lcnt, exp.ts, exp.tl, exp.lcnt);
      end
      if (ts === 1'b1 && first_ts < 0) first_ts = j;
      if (tl === 1'b1 && first_tl < 0) first_tl = j;
    end
    n_checks++;
    if (first_ts != S * EP) begin
      n_fail++; $display("FAIL restart_first_ts: got %0d want %0d", first_ts, S * EP);
    end
    n_checks++;
    if (first_tl != L * EP) begin
      n_fail++; $display("FAIL restart_first_tl: got %0d want %0d", first_tl, L * EP);
    end
  endtask

  task automatic test_st_coincident();
    out_t got, exp;
    int first_ts = -1;
    int pulses   = 0;
    drive(1'b0, 1'b1);
    void'(sb.pop_front());
    for (int k = 2; k <= S * EP; k++) begin
      drive(1'b0, 1'b0);
      got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL coinc_pre cycle=%0d: got ts=%b tl=%b lcnt=%0d, want ts=%b tl=%b lcnt=%0d",
                 k, got.ts, got.tl, got.lcnt, exp.ts, exp.tl, exp.lcnt);
      end
    end
    n_checks++;
    if (ts !== 1'b1) begin
      n_fail++; $display("FAIL coinc_setup_ts: got %b want 1", ts);
    end
    drive(1'b1, 1'b0);
    got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
    if (got !== exp || ts !== 1'b0) begin
      n_fail++;
      $display("FAIL coinc_clear: got ts=%b tl=%b lcnt=%0d, want all 0", got.ts, got.tl, got.lcnt);
    end
    for (int j = 2; j <= 2 * S * EP + 1; j++) begin
      drive(1'b0, 1'b0);
      got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL coinc_post cycle=%0d: got ts=%b tl=%b lcnt=%0d, want ts=%b tl=%b lcnt=%0d",
                 j, got.ts, got.tl, got.lcnt, exp.ts, exp.tl, exp.lcnt);
      end
      if (ts === 1'b1) begin
        pulses++;
        if (first_ts < 0) first_ts = j;
      end
    end
    n_checks++;
    if (first_ts != S * EP) begin
      n_fail++; $display("FAIL coinc_first_ts: got %0d want %0d", first_ts, S * EP);
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++; $display("FAIL coinc_pulse_count: got %0d want 2", pulses);
    end
  endtask

  task automatic test_st_held();
    out_t got, exp;
    int first_ts = -1;
    drive(1'b0, 1'b1);
    void'(sb.pop_front());
    for (int k = 2; k <= L * EP + 2; k++) begin
      drive(1'b0, 1'b0);
      got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL held_pre cycle=%0d: got ts=%b tl=%b lcnt=%0d, want ts=%b tl=%b lcnt=%0d",
                 k, got.ts, got.tl, got.lcnt, exp.ts, exp.tl, exp.lcnt);
      end
    end
    n_checks++;
    if (tl !== 1'b1) begin
      n_fail++; $display("FAIL held_setup_tl: got %b want 1", tl);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0);
      got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
      if (got !== exp || got !== out_t'(0)) begin
        n_fail++;
        $display("FAIL held_st i=%0d: got ts=%b tl=%b lcnt=%0d, want all 0", i, got.ts, got.tl, got.lcnt);
      end
    end
    for (int j = 2; j <= S * EP + 1; j++) begin
      drive(1'b0, 1'b0);
      got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL held_post cycle=%0d: got ts=%b tl=%b lcnt=%0d, want ts=%b tl=%b lcnt=%0d",
                 j, got.ts, got.tl, got.lcnt, exp.ts, exp.tl, exp.lcnt);
      end
      if (ts === 1'b1 && first_ts < 0) first_ts = j;
    end
    n_checks++;
    if (first_ts != S * EP) begin
      n_fail++; $display("FAIL held_first_ts: got %0d want %0d", first_ts, S * EP);
    end
  endtask

  task automatic test_rst_mid();
    out_t got, exp;
    int first_ts = -1;
    int first_tl = -1;
    drive(1'b0, 1'b1);
    void'(sb.pop_front());
    for (int k = 2; k <= L * EP + 3; k++) begin
      drive(1'b0, 1'b0);
      got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rstmid_pre cycle=%0d: got ts=%b tl=%b lcnt=%0d, want ts=%b tl=%b lcnt=%0d",
                 k, got.ts, got.tl, got.lcnt, exp.ts, exp.tl, exp.lcnt);
      end
    end
    n_checks++;
    if (tl !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_setup_tl: got %b want 1", tl);
    end
    drive(1'b1, 1'b1);
    got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
    if (got !== exp || got !== out_t'(0)) begin
      n_fail++;
      $display("FAIL rstmid_clear: got ts=%b tl=%b lcnt=%0d, want all 0", got.ts, got.tl, got.lcnt);
    end
    for (int j = 2; j <= L * EP + 1; j++) begin
      drive(1'b0, 1'b0);
      got = {ts, tl, lcnt}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rstmid_post cycle=%0d: got ts=%b tl=%b lcnt=%0d, want ts=%b tl=%b lcnt=%0d",
                 j, got.ts, got.tl, got.lcnt, exp.ts, exp.tl, exp.lcnt);
      end
      if (ts === 1'b1 && first_ts < 0) first_ts = j;
      if (tl === 1'b1 && first_tl < 0) first_tl = j;
    end
    n_checks++;
    if (first_ts != S * EP) begin
      n_fail++; $display("FAIL rstmid_first_ts: got %0d want %0d", first_ts, S * EP);
    end
    n_checks++;
    if (first_tl != L * EP) begin
      n_fail++; $display("FAIL rstmid_first_tl: got %0d want %0d", first_tl, L * EP);
    end
  endtask

  initial begin
    test_reset();
    test_st_restart();
    test_st_coincident();
    test_st_held();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
